// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit scanned 7-segment driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// Anode codes are active-low, bit i enables digit i.
package seg_pkg;

  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_NONE = 4'hF;
  localparam logic [3:0] AN_D0   = 4'hE;
  localparam logic [3:0] AN_D1   = 4'hD;
  localparam logic [3:0] AN_D2   = 4'hB;
  localparam logic [3:0] AN_D3   = 4'h7;

  function automatic logic [3:0] an_code(input scan_idx_t idx);
    logic [3:0] code;
    code = AN_NONE;
    case (idx)
      SCAN_D0: code = AN_D0;
      SCAN_D1: code = AN_D1;
      SCAN_D2: code = AN_D2;
      SCAN_D3: code = AN_D3;
      default: code = AN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the BCD source / display pins and seg_scan_driver.
//   load, hundreds, tens, ones, blank_lz : source -> driver
//   anode, seg, dp, slot_tick            : driver -> display / observers
// master = the side driving digits; slave = the driver itself.
interface seg_scan_driver_if;
  logic       load;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       slot_tick;

  modport master (
    output load, hundreds, tens, ones, blank_lz,
    input  anode, seg, dp, slot_tick
  );

  modport slave (
    input  load, hundreds, tens, ones, blank_lz,
    output anode, seg, dp, slot_tick
  );
endinterface

// File: rtl/seg_decode.sv
// Combinational BCD -> active-low 7-segment decoder.
//   bcd : 4-bit digit code; 10..15 render as a dash
//   seg : active-low segments {g,f,e,d,c,b,a}
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg_scan_driver_if
//              (load/hundreds/tens/ones/blank_lz in; anode/seg/dp/slot_tick out)
// Each digit slot lasts PRESCALE cycles; the anode is released for the
// first cycle of every slot to avoid ghosting. Digit 3 is always blank.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int unsigned   PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  scan_idx_t     idx, idx_next;
  logic          tick;
  logic [3:0]    d2, d1, d0;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    dec_seg;
  logic [3:0]    anode_next;
  logic [6:0]    seg_next;
  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic          tick_q;

  assign tick = (pcnt == LAST);

  seg_decode u_decode (
    .bcd (digit),
    .seg (dec_seg)
  );

  // Invalid codes are non-zero, so they never satisfy the zero tests.
  always_comb begin
    idx_next = idx;
    digit    = '0;
    blank    = 1'b0;
    case (idx)
      SCAN_D0: begin
        digit = d0;
        if (tick) idx_next = SCAN_D1;
      end
      SCAN_D1: begin
        digit = d1;
        blank = bus.blank_lz && (d2 == 4'd0) && (d1 == 4'd0);
        if (tick) idx_next = SCAN_D2;
      end
      SCAN_D2: begin
        digit = d2;
        blank = bus.blank_lz && (d2 == 4'd0);
        if (tick) idx_next = SCAN_D3;
      end
      SCAN_D3: begin
        blank = 1'b1;
        if (tick) idx_next = SCAN_D0;
      end
      default: idx_next = SCAN_D0;
    endcase
    anode_next = (pcnt == '0) ? AN_NONE : an_code(idx);
    seg_next   = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      idx     <= SCAN_D0;
      d2      <= '0;
      d1      <= '0;
      d0      <= '0;
      anode_q <= AN_NONE;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      pcnt    <= tick ? '0 : pcnt + 1'b1;
      idx     <= idx_next;
      if (bus.load) begin
        d2 <= bus.hundreds;
        d1 <= bus.tens;
        d0 <= bus.ones;
      end
      anode_q <= anode_next;
      seg_q   <= seg_next;
      tick_q  <= tick;
    end
  end

  assign bus.anode     = anode_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = 1'b1;
  assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int P = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: elapsed cycles since reset plus the latched digits.
  int         cyc;
  logic [3:0] m2, m1, m0;
  logic [3:0] e_anode;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_tick;

  // Lit segments (active-high {g..a}) of the standard glyphs.
  logic [6:0] lit [10];
  initial begin
    lit[0] = 7'h3F; lit[1] = 7'h06; lit[2] = 7'h5B; lit[3] = 7'h4F;
    lit[4] = 7'h66; lit[5] = 7'h6D; lit[6] = 7'h7D; lit[7] = 7'h07;
    lit[8] = 7'h7F; lit[9] = 7'h6F;
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    if (v > 4'd9) return 7'b0111111;
    return ~lit[v];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the registered outputs, check after the edge.
  task automatic step(input logic r, input logic l, input logic [3:0] h,
                      input logic [3:0] t, input logic [3:0] o, input logic b);
    int pc;
    int ix;
    rst          = r;
    bus.load     = l;
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
    bus.blank_lz = b;
    if (r) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      cyc = 0; m2 = 0; m1 = 0; m0 = 0;
    end else begin
      pc      = cyc % P;
      ix      = (cyc / P) % 4;
      e_anode = (pc == 0) ? 4'hF : (4'hF & ~(4'b0001 << ix));
      case (ix)
        0:       e_seg = glyph(m0);
        1:       e_seg = (b && m2 == 0 && m1 == 0) ? 7'h7F : glyph(m1);
        2:       e_seg = (b && m2 == 0) ? 7'h7F : glyph(m2);
        default: e_seg = 7'h7F;
      endcase
      e_dp   = 1'b1;
      e_tick = (pc == P - 1);
      cyc++;
      if (l) begin m2 = h; m1 = t; m0 = o; end
    end
    @(negedge clk);
    check_eq("anode", 32'(bus.anode), 32'(e_anode));
    check_eq("seg", 32'(bus.seg), 32'(e_seg));
    check_eq("dp", 32'(bus.dp), 32'(e_dp));
    check_eq("slot_tick", 32'(bus.slot_tick), 32'(e_tick));
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, b);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    m2 = 0; m1 = 0; m0 = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.hundreds = '0; bus.tens = '0; bus.ones = '0; bus.blank_lz = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(4 * P + 1, 1'b0);

    step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
    idle(4 * P, 1'b0);

    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    idle(4 * P, 1'b1);

    step(1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 1'b1);
    idle(4 * P, 1'b1);

    step(1'b0, 1'b1, 4'd0, 4'hC, 4'd0, 1'b0);
    idle(4 * P, 1'b0);
    idle(4 * P, 1'b1);

    // load exactly on a tick cycle
    while ((cyc % P) != P - 1) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd4, 4'd8, 4'd9, 1'b0);
    idle(2 * P, 1'b0);

    // reset mid-slot
    while ((cyc % P) != 1 || ((cyc / P) % 4) != 2) step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(3 * P, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic       r, l, b;
      logic [3:0] h, t, o;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 7) == 0);
      b = $urandom_range(0, 1) == 1;
      h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      o = 4'($urandom_range(0, 15));
      step(r, l, h, t, o, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed 4-digit common-anode 7-segment display driver. It sits directly downstream of the binary-to-BCD converter and takes its hundreds/tens/ones digits. Digits are captured on a load strobe, one digit is scanned per refresh slot, and leading zeros can be suppressed. Invalid codes show a dash. Anode and segment outputs are registered and active-low, with a one-cycle dead time between digits to prevent ghosting.

## Interface
- PRESCALE, 50000: clock cycles per digit slot; legal range 2..2^20.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  capture hundreds/tens/ones this cycle
- hundreds  in  4  BCD digit 2
- tens  in  4  BCD digit 1
- ones  in  4  BCD digit 0
- blank_lz  in  1  leading-zero suppression enable; sampled live, not latched
- anode  out  4  active-low digit enables; bit i selects digit i
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low; constant 1 (off) after reset
- slot_tick  out  1  one-cycle pulse at each slot boundary

## Operation
- Latched digit registers d2/d1/d0 load from hundreds/tens/ones when load=1.
  - The new value is visible in outputs from the second cycle after load.
- Prescale counter pcnt counts 0..PRESCALE-1 and wraps.
  - tick = (pcnt==PRESCALE-1).
  - On tick, scan index idx (2 bits) increments 0→1→2→3→0.
- Slot states per idx:
  - SCAN_D0: shows d0.
  - SCAN_D1: shows d1.
  - SCAN_D2: shows d2.
  - SCAN_D3: digit 3 is always blank; anode[3]=0 is asserted but seg=7'h7F.
- Decode, via the sub-module:
  - 0-9 produce the standard patterns.
  - 10-15 produce a dash (seg=7'b0111111, only g lit).
- Leading-zero suppression, when blank_lz=1:
  - Digit 2 is blank if d2==0.
  - Digit 1 is blank if d2==0 and d1==0.
  - Digit 0 is never blanked.
  - Invalid codes are never treated as zero.
- Dead time: in the first cycle of every slot (pcnt==0), anode=4'hF. In all other cycles the anode is the one-hot-low code of idx.
- slot_tick is a registered copy of tick.

## Timing
- Reset values:
  - anode=4'hF, seg=7'h7F, dp=1, slot_tick=0.
  - d2=d1=d0=0, idx=0, pcnt=0.
- Outputs are registered: anode/seg at cycle n reflect idx, pcnt, d* and blank_lz from cycle n-1.
- After reset release:
  - The first cycle shows anode=F.
  - The digit-0 anode asserts on the second cycle after release (pcnt=1).
- Slot length is exactly PRESCALE cycles. The full frame is 4×PRESCALE.
- load coinciding with tick: both take effect. The new digits are shown in the next slot.
- load held high: d* track the inputs every cycle.
- Reset asserted mid-slot returns all state to reset values on the next edge; no partial slot completes.
- The pcnt width is clog2(PRESCALE). Wrap must never pass PRESCALE-1.

## Structure
- Package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - anode codes AN_NONE=4'hF, AN_D0..AN_D3;
  - the scan_idx_t typedef (2-bit).
- Sub-module seg_decode: a purely combinational 4-bit BCD → 7-bit active-low segments decoder.
- Top module: prescaler, scan index, digit latch, blanking logic, output registers.

## Test plan
- Reset, PRESCALE=4, no load:
  - anode sequence per slot is F,E,E,E then F,D,D,D then F,B,B,B then F,7,7,7;
  - seg shows SEG_0 for digits 0-2 and 7F for digit 3.
- load with 1/2/3 (hundreds/tens/ones), blank_lz=0: over one frame, seg is SEG_3 under anode E, SEG_2 under D, SEG_1 under B.
- Digits 0/0/7 with blank_lz=1:
  - digit 0 shows SEG_7;
  - digits 1, 2 and 3 show 7F.
- Digits 0/0/7, then 0/5/0: digit 1 shows SEG_5 and digit 2 is blank. Digit 0 shows SEG_0, because the ones digit is never blanked.
- tens=4'hC: digit 1 shows 7'b0111111 regardless of blank_lz.
- Stimulus during the frame:
  - load on a tick cycle: the new value appears in the following slot;
  - rst pulsed mid-slot: the next cycle gives anode=F and seg=7F, and pcnt/idx restart from 0.
